main_memory_burst: RTL and testbench
====================================

// Module: main_memory_burst
// PURPOSE
// - Main-memory stage directly below the lab cache. It serves block refills (reads) and block write-backs (writes).
// - Transfers are one-word beats on a 32-bit bus, after a fixed access latency.
// - Uses a level request / one-cycle done handshake so the cache FSM can stall on miss until mem_done.
// PARAMETERS
// - ADDR_W       10   byte-address width (1 KiB space)
// - MEM_WORDS    256  32-bit words of storage (= 2**(ADDR_W-2))
// - BLOCK_WORDS  4    words per cache block; power of 2, >= 1
// - LATENCY      4    cycles from request acceptance to first beat; >= 1
// PORTS
// - clk        in   1       rising-edge clock
// - rst        in   1       asynchronous, active-high reset
// - mem_req    in   1       level request from cache; sampled only in IDLE
// - mem_we     in   1       1 = block write-back, 0 = block read; captured on accept
// - mem_addr   in   ADDR_W  byte address; low log2(BLOCK_WORDS*4) bits ignored (block-aligned)
// - mem_wdata  in   32      write word for the current beat; valid while mem_wready=1
// - mem_rdata  out  32      read word for the current beat; 0 when mem_rvalid=0
// - mem_rvalid out  1       read beat valid
// - mem_wready out  1       write beat taken at the end of this cycle
// - mem_beat   out  log2(BLOCK_WORDS) (min 1)  index of the current beat
// - mem_busy   out  1       1 whenever state != IDLE
// - mem_done   out  1       one-cycle pulse, the cycle after the last beat
// BEHAVIOUR
// - Reset (asynchronous, immediate):
//   - state=IDLE; all outputs 0; latency counter and beat counter cleared.
//   - Array contents are NOT reset. Simulation init: word i = i.
// - FSM states: IDLE -> WAIT -> XFER -> DONE -> IDLE.
// - IDLE: when mem_req=1 at a rising edge (cycle N), capture:
//   - base word = mem_addr[ADDR_W-1:2] with low log2(BLOCK_WORDS) bits cleared;
//   - mem_we;
//   - load latency counter with LATENCY-1;
//   - go to WAIT.
// - WAIT: decrement the counter each cycle; on 0, go to XFER. The first beat occurs in cycle N+LATENCY.
// - XFER: beat k (k = 0..BLOCK_WORDS-1) occupies one cycle, back-to-back, with mem_beat=k.
//   - Read: mem_rvalid=1; mem_rdata = mem[base+k] (combinational from array).
//   - Write: mem_wready=1; mem[base+k] <= mem_wdata at the closing edge.
//   - After beat BLOCK_WORDS-1, go to DONE.
// - DONE: mem_done=1 for exactly one cycle, then IDLE.
//   - Cache must drop mem_req by the DONE edge.
//   - A req still high in the following IDLE cycle starts a new transfer (by design, no dedupe).
// - mem_req/mem_we/mem_addr changes while busy are ignored. There is no abort.
// - Word index arithmetic is modulo MEM_WORDS. Because the base is aligned, a block never wraps.
// - Reset mid-transfer: return to IDLE immediately, with no done pulse. Words already written stay written.
// - Total occupancy per request: LATENCY + BLOCK_WORDS + 1 cycles (defaults: 9).
// - Single clock domain; no combinational path from inputs to mem_done/mem_busy.
// STRUCTURE
// - Shared package mem_pkg:
//   - FSM state encoding (IDLE, WAIT, XFER, DONE);
//   - ADDR_W, BLOCK_WORDS, word/offset width constants;
//   - block-base masking function, shared with the cache.
// - Sub-module main_mem_array: MEM_WORDS x 32 storage with one async read port and one sync write port.
// - FSM, counters and the handshake logic stay in this module.
// TESTING
// - Reset then read, addr=0x14 (word 5) -> base word 4; rvalid in cycles N+4..N+7;
//   rdata 4,5,6,7; beat 0..3; done at N+8; busy N+1..N+8.
// - Write, addr=0x6C (word 27), wdata beats 0x114514,0x1,0x2,0x3 -> words 24..27 updated;
//   a subsequent read of 0x60 returns the same four values.
// - Hold mem_req high through DONE -> a second transfer is accepted in the IDLE cycle after done;
//   addr toggled during WAIT has no effect.
// - Assert rst during beat 2 of a write -> outputs 0 immediately, no done;
//   words 0..1 of the block are updated, words 2..3 are unchanged.
// - Top block, addr=0x3F0 -> words 252..255 only, no wrap.
//   With LATENCY=1, BLOCK_WORDS=1 -> first beat at N+1, done at N+2.
// - Idle with mem_req=0 for 20 cycles -> busy, rvalid, wready and done stay 0; rdata=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory stage and the cache above it.
// Holds the default geometry, the transfer FSM encoding and block-base masking.
package mem_pkg;
  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int LATENCY     = 4;
  localparam int WORD_W      = ADDR_W - 2;
  localparam int MEM_WORDS   = 2 ** WORD_W;
  localparam int OFFSET_W    = $clog2(BLOCK_WORDS * 4);
  localparam int BEAT_W      = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Word index of the first word of the block holding byte_addr.
  function automatic logic [31:0] block_base_word(input logic [31:0] byte_addr,
                                                  input int unsigned block_words);
    return (byte_addr >> 2) & ~(block_words - 1);
  endfunction
endpackage

// File: rtl/main_mem_array.sv
// Word storage for main memory: one asynchronous read port, one synchronous write port.
// Contents are deliberately not reset.
module main_mem_array #(
  parameter int WORDS = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/main_memory_burst.sv
// Burst main memory below the cache: fixed access latency, then one 32-bit beat per cycle
// for a whole block, closed by a one-cycle done pulse.
module main_memory_burst
  import mem_pkg::*;
#(
  parameter int ADDR_W      = mem_pkg::ADDR_W,
  parameter int MEM_WORDS   = mem_pkg::MEM_WORDS,
  parameter int BLOCK_WORDS = mem_pkg::BLOCK_WORDS,
  parameter int LATENCY     = mem_pkg::LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_rvalid,
  output logic              mem_wready,
  output logic [((BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1)-1:0] mem_beat,
  output logic              mem_busy,
  output logic              mem_done
);
  localparam int WRD_W = ADDR_W - 2;
  localparam int BT_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int LAT_W = $clog2(LATENCY + 1);

  mem_state_e       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [BT_W-1:0]  beat_q, beat_d;
  logic [WRD_W-1:0] base_q, base_d;
  logic             we_q, we_d;
  logic [WRD_W-1:0] word_addr;
  logic [31:0]      array_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      we_q    <= we_d;
    end
  end

  // WAIT lasts LATENCY-1 cycles so the first beat lands LATENCY cycles after the accept cycle.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    base_d  = base_q;
    we_d    = we_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          base_d  = WRD_W'(block_base_word(32'(mem_addr), BLOCK_WORDS));
          we_d    = mem_we;
          lat_d   = LAT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_XFER : ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q <= LAT_W'(1)) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (beat_q == BT_W'(BLOCK_WORDS - 1)) begin
          beat_d  = '0;
          state_d = ST_DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The base is block-aligned, so adding the beat index never carries out of the block.
  assign word_addr  = base_q + WRD_W'(beat_q);
  assign mem_busy   = (state_q != ST_IDLE);
  assign mem_done   = (state_q == ST_DONE);
  assign mem_rvalid = (state_q == ST_XFER) && !we_q;
  assign mem_wready = (state_q == ST_XFER) && we_q;
  assign mem_beat   = beat_q;
  assign mem_rdata  = mem_rvalid ? array_rdata : 32'h0;

  main_mem_array #(
    .WORDS (MEM_WORDS),
    .AW    (WRD_W),
    .DW    (32)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_wready),
    .addr_i  (word_addr),
    .wdata_i (mem_wdata),
    .rdata_o (array_rdata)
  );
endmodule

// File: tb/tb_main_memory_burst.sv
// Directed bench for main_memory_burst: default geometry plus a LATENCY=1, BLOCK_WORDS=1 instance.
// Memory is preloaded with word i = i through write bursts before the directed steps.
module tb_main_memory_burst;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_rvalid, mem_wready, mem_busy, mem_done;
  logic [1:0]  mem_beat;

  logic        req1, we1;
  logic [9:0]  addr1;
  logic [31:0] wdata1, rdata1;
  logic        rvalid1, wready1, busy1, done1;
  logic [0:0]  beat1;

  logic [31:0] model_mem [256];
  logic [31:0] exp_q [$];
  logic [31:0] wd [4];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  main_memory_burst dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wready(mem_wready), .mem_beat(mem_beat), .mem_busy(mem_busy), .mem_done(mem_done)
  );

  main_memory_burst #(.ADDR_W(10), .MEM_WORDS(256), .BLOCK_WORDS(1), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_rvalid(rvalid1),
    .mem_wready(wready1), .mem_beat(beat1), .mem_busy(busy1), .mem_done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   32'(mem_busy),   32'h0);
    check({tag, "_rvalid"}, 32'(mem_rvalid), 32'h0);
    check({tag, "_wready"}, 32'(mem_wready), 32'h0);
    check({tag, "_done"},   32'(mem_done),   32'h0);
    check({tag, "_rdata"},  mem_rdata,       32'h0);
  endtask

  // Called at a falling edge with the DUT idle; that cycle is the accept cycle N.
  task automatic xfer(input logic [9:0] addr, input logic we, input logic [31:0] wdv [4],
                      input bit hold, input int rst_at);
    int base;
    logic [31:0] e;
    base = int'(addr[9:4]) * 4;
    check("accept_busy", 32'(mem_busy), 32'h0);
    mem_req  = 1'b1;
    mem_we   = we;
    mem_addr = addr;
    if (!we) for (int k = 0; k < 4; k++) exp_q.push_back(model_mem[base + k]);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!hold) mem_req = 1'b0;
        mem_we   = 1'($urandom_range(0, 1));
        mem_addr = 10'($urandom_range(0, 1023));
      end
      check("wait_busy",   32'(mem_busy),   32'h1);
      check("wait_rvalid", 32'(mem_rvalid), 32'h0);
      check("wait_wready", 32'(mem_wready), 32'h0);
      check("wait_done",   32'(mem_done),   32'h0);
      check("wait_rdata",  mem_rdata,       32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check_quiet("rst_mid");
        check("rst_mid_beat", 32'(mem_beat), 32'h0);
        exp_q.delete();
        return;
      end
      check("beat_idx",    32'(mem_beat),   32'(k));
      check("beat_busy",   32'(mem_busy),   32'h1);
      check("beat_rvalid", 32'(mem_rvalid), 32'(!we));
      check("beat_wready", 32'(mem_wready), 32'(we));
      check("beat_done",   32'(mem_done),   32'h0);
      if (we) begin
        mem_wdata = wdv[k];
        model_mem[base + k] = wdv[k];
      end else if (exp_q.size() == 0) begin
        n_total++;
        $error("FAIL scoreboard_empty observed=0x%0h expected=none", mem_rdata);
      end else begin
        e = exp_q.pop_front();
        check("beat_rdata", mem_rdata, e);
      end
    end
    @(negedge clk);
    check("done_pulse",  32'(mem_done),   32'h1);
    check("done_busy",   32'(mem_busy),   32'h1);
    check("done_rvalid", 32'(mem_rvalid), 32'h0);
    check("done_wready", 32'(mem_wready), 32'h0);
    @(negedge clk);
    check("after_done",  32'(mem_done),   32'h0);
    check("after_busy",  32'(mem_busy),   32'h0);
  endtask

  initial begin
    rst = 1'b1;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    check_quiet("in_reset");
    check("in_reset_beat", 32'(mem_beat), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Preload word i = i.
    for (int b = 0; b < 64; b++) begin
      for (int k = 0; k < 4; k++) wd[k] = 32'(b * 4 + k);
      xfer(10'(b * 16), 1'b1, wd, 1'b0, -1);
    end

    rst = 1'b1;
    @(negedge clk);
    check_quiet("reset2");
    rst = 1'b0;
    @(negedge clk);

    // Read of word 5 returns block 4..7.
    xfer(10'h014, 1'b0, wd, 1'b0, -1);

    // Write-back then read of the same block.
    wd[0] = 32'h0011_4514; wd[1] = 32'h1; wd[2] = 32'h2; wd[3] = 32'h3;
    xfer(10'h06C, 1'b1, wd, 1'b0, -1);
    xfer(10'h060, 1'b0, wd, 1'b0, -1);

    // Request held high through DONE is accepted again in the following IDLE cycle.
    xfer(10'h020, 1'b0, wd, 1'b1, -1);
    xfer(10'h040, 1'b0, wd, 1'b0, -1);

    // Reset during beat 2 of a write: only beats 0 and 1 land.
    for (int k = 0; k < 4; k++) wd[k] = 32'hA5A5_0000 + 32'(k);
    xfer(10'h080, 1'b1, wd, 1'b0, 2);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_quiet("post_rst");
    end
    xfer(10'h080, 1'b0, wd, 1'b0, -1);

    // Top block: no wrap into block 0.
    xfer(10'h3F0, 1'b0, wd, 1'b0, -1);
    for (int k = 0; k < 4; k++) wd[k] = $urandom;
    xfer(10'h3F4, 1'b1, wd, 1'b0, -1);
    xfer(10'h3FC, 1'b0, wd, 1'b0, -1);
    xfer(10'h000, 1'b0, wd, 1'b0, -1);

    // Idle with no request.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_quiet("idle");
    end

    // LATENCY=1, BLOCK_WORDS=1: beat at N+1, done at N+2.
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h008;
    @(negedge clk);
    req1 = 1'b0;
    check("l1w_wready", 32'(wready1), 32'h1);
    check("l1w_beat",   32'(beat1),   32'h0);
    check("l1w_busy",   32'(busy1),   32'h1);
    wdata1 = 32'hCAFE_0001;
    @(negedge clk);
    check("l1w_done",   32'(done1),   32'h1);
    check("l1w_wready2", 32'(wready1), 32'h0);
    @(negedge clk);
    check("l1w_idle",   32'(busy1),   32'h0);
    exp_q.push_back(32'hCAFE_0001);
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h00B;
    @(negedge clk);
    req1 = 1'b0;
    check("l1r_rvalid", 32'(rvalid1), 32'h1);
    check("l1r_rdata",  rdata1,       exp_q.pop_front());
    @(negedge clk);
    check("l1r_done",   32'(done1),   32'h1);
    check("l1r_rdata0", rdata1,       32'h0);
    @(negedge clk);
    check("l1r_done_clr", 32'(done1), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
